// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline-register definitions for the IF/ID stage and its successors.
package if_id_skid_reg_pkg;

    localparam int unsigned PIPE_INSTR_W = 32;
    localparam int unsigned PIPE_PC_W    = 32;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg_slot.sv
// One-entry skid slot: state bit plus PC/instruction storage with load/drain/clear.
module pipe_skid_slot
    import if_id_skid_reg_pkg::*;
#(
    parameter int unsigned PC_W    = PIPE_PC_W,
    parameter int unsigned INSTR_W = PIPE_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               full,
    output logic [PC_W-1:0]    slot_pc,
    output logic [INSTR_W-1:0] slot_instr
);

    skid_state_e state;

    // Clear dominates so a flush also kills a word loaded in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SKID_EMPTY;
        end else if (clear) begin
            state <= SKID_EMPTY;
        end else if (load) begin
            state <= SKID_FULL;
        end else if (drain) begin
            state <= SKID_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            slot_pc    <= in_pc;
            slot_instr <= in_instr;
        end
    end

    always_comb begin
        full = (state == SKID_FULL);
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid, hold, flush, optional skid slot and stall counter.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int unsigned        INSTR_W   = PIPE_INSTR_W,
    parameter int unsigned        PC_W      = PIPE_PC_W,
    parameter bit                 SKID_EN   = 1'b1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               skid_full,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               transfer;
    logic               slot_full;
    logic               slot_load;
    logic               slot_drain;
    logic               slot_clear;
    logic [PC_W-1:0]    slot_pc;
    logic [INSTR_W-1:0] slot_instr;

    // Without the skid slot, acceptance follows hold combinationally; with it,
    // in_ready is the registered slot-empty flag.
    always_comb begin
        in_ready   = SKID_EN ? ~slot_full : ~hold;
        transfer   = in_valid & in_ready;
        slot_load  = SKID_EN & ~flush & hold & transfer;
        slot_drain = ~flush & ~hold & slot_full;
        slot_clear = flush;
        skid_full  = slot_full;
    end

    pipe_skid_slot #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (slot_load),
        .drain      (slot_drain),
        .clear      (slot_clear),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .full       (slot_full),
        .slot_pc    (slot_pc),
        .slot_instr (slot_instr)
    );

    // A bubble keeps the last PC and forces the NOP encoding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= NOP_INSTR;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
        end else if (!hold) begin
            if (slot_full) begin
                out_valid <= 1'b1;
                out_pc    <= slot_pc;
                out_instr <= slot_instr;
            end else if (transfer) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
            end else begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (hold && out_valid && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
